// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the uart_tx arbiter: FSM state encoding and
// wrapped round-robin index arithmetic.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND
  } state_e;

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and uart_tx-side signals of the arbiter, plus grant/error status.
// master is the arbiter's view; slave is the view of the surrounding logic.
interface uart_tx_arbiter_if #(
  parameter int unsigned N = 4
);
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_data;
  logic           tx_data_valid;
  logic           tx_data_ready;
  logic [N-1:0]   grant;
  logic           busy;
  logic [N-1:0]   timeout_err;
  logic           err_clr;

  modport master (
    input  req_data, req_valid, req_last, tx_data_ready, err_clr,
    output req_ready, tx_data, tx_data_valid, grant, busy, timeout_err
  );

  modport slave (
    output req_data, req_valid, req_last, tx_data_ready, err_clr,
    input  req_ready, tx_data, tx_data_valid, grant, busy, timeout_err
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or above i_ptr,
// wrapping modulo N, returned one-hot.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_win,
  output logic          o_any
);

  logic          w_found;
  logic [PW-1:0] w_idx;

  always_comb begin
    o_win   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned off = 0; off < N; off++) begin
      w_idx = PW'((32'(i_ptr) + off) % N);
      if (!w_found && i_req[w_idx]) begin
        o_win[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one uart_tx byte transmitter
// between N requesters, with burst limit and stall timeout.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter int unsigned MAX_BURST = 64,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_tx_arbiter_if.master   bus
);

  localparam int unsigned PW = $clog2(N);
  localparam int unsigned BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam int unsigned IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e        r_state, w_state_d;
  logic [N-1:0]  r_grant, w_grant_d;
  logic [PW-1:0] r_gidx, w_gidx_d;
  logic [PW-1:0] r_ptr, w_ptr_d;
  logic [7:0]    r_tx_data, w_tx_data_d;
  logic          r_tx_valid, w_tx_valid_d;
  logic          r_hold_last, w_hold_last_d;
  logic [BW-1:0] r_byte_cnt, w_byte_cnt_d;
  logic [IW-1:0] r_idle_cnt, w_idle_cnt_d;
  logic [N-1:0]  r_timeout_err, w_timeout_err_d;

  logic [N-1:0]  w_win;
  logic          w_any;
  logic [PW-1:0] w_win_idx;
  logic [7:0]    w_bytes [N];
  logic          w_release;

  rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_rr_pick (
    .i_req (bus.req_valid),
    .i_ptr (r_ptr),
    .o_win (w_win),
    .o_any (w_any)
  );

  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < N; i++) begin
      w_bytes[i] = bus.req_data[8*i +: 8];
      if (w_win[i]) w_win_idx = PW'(i);
    end
  end

  always_comb begin
    w_state_d       = r_state;
    w_grant_d       = r_grant;
    w_gidx_d        = r_gidx;
    w_ptr_d         = r_ptr;
    w_tx_data_d     = r_tx_data;
    w_tx_valid_d    = r_tx_valid;
    w_hold_last_d   = r_hold_last;
    w_byte_cnt_d    = r_byte_cnt;
    w_idle_cnt_d    = r_idle_cnt;
    w_timeout_err_d = bus.err_clr ? '0 : r_timeout_err;
    w_release       = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_grant_d    = w_win;
          w_gidx_d     = w_win_idx;
          w_byte_cnt_d = '0;
          w_idle_cnt_d = '0;
          w_state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        if (bus.req_valid[r_gidx]) begin
          w_tx_data_d   = w_bytes[r_gidx];
          w_hold_last_d = bus.req_last[r_gidx];
          w_tx_valid_d  = 1'b1;
          w_byte_cnt_d  = r_byte_cnt + BW'(1);
          w_idle_cnt_d  = '0;
          w_state_d     = S_SEND;
        end else if (TIMEOUT > 0 && r_idle_cnt == IW'(TIMEOUT - 1)) begin
          // Set wins over a simultaneous err_clr for the timed-out bit.
          w_timeout_err_d[r_gidx] = 1'b1;
          w_release               = 1'b1;
        end else begin
          w_idle_cnt_d = r_idle_cnt + IW'(1);
        end
      end
      S_SEND: begin
        // uart_tx samples valid while idle, so valid must drop right after the handshake.
        if (r_tx_valid && bus.tx_data_ready) begin
          w_tx_valid_d = 1'b0;
          if (r_hold_last || (MAX_BURST > 0 && r_byte_cnt == BW'(MAX_BURST))) begin
            w_release = 1'b1;
          end else begin
            w_state_d = S_LOAD;
          end
        end
      end
      default: w_state_d = S_IDLE;
    endcase

    if (w_release) begin
      w_grant_d = '0;
      w_ptr_d   = PW'(wrap_inc(32'(r_gidx), N));
      w_state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_grant       <= '0;
      r_gidx        <= '0;
      r_ptr         <= '0;
      r_tx_data     <= '0;
      r_tx_valid    <= 1'b0;
      r_hold_last   <= 1'b0;
      r_byte_cnt    <= '0;
      r_idle_cnt    <= '0;
      r_timeout_err <= '0;
    end else begin
      r_state       <= w_state_d;
      r_grant       <= w_grant_d;
      r_gidx        <= w_gidx_d;
      r_ptr         <= w_ptr_d;
      r_tx_data     <= w_tx_data_d;
      r_tx_valid    <= w_tx_valid_d;
      r_hold_last   <= w_hold_last_d;
      r_byte_cnt    <= w_byte_cnt_d;
      r_idle_cnt    <= w_idle_cnt_d;
      r_timeout_err <= w_timeout_err_d;
    end
  end

  assign bus.req_ready     = (r_state == S_LOAD) ? r_grant : '0;
  assign bus.tx_data       = r_tx_data;
  assign bus.tx_data_valid = r_tx_valid;
  assign bus.grant         = r_grant;
  assign bus.busy          = |r_grant;
  assign bus.timeout_err   = r_timeout_err;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx byte transmitter between N requesters.
- Arbitration is round-robin at packet granularity. The grant holds until the requester marks the last byte, a burst limit is reached, or the requester stalls past a timeout.
- Sits between on-chip byte sources (debug/PMU dump, log streams) and the uart_tx data/valid/ready interface.

Parameters:
- N, 4, number of requesters (2..16).
- MAX_BURST, 64, bytes per grant before forced release; 0 = unlimited.
- TIMEOUT, 1024, idle cycles allowed while granted before forced release; 0 = disabled.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_data  in  N*8  byte from requester i at bits [8i+7:8i]
- req_valid  in  N  requester i has a byte
- req_last  in  N  byte is the last of the packet
- req_ready  out  N  requester i byte accepted when req_valid[i]&&req_ready[i]
- tx_data  out  8  to uart_tx tx_data
- tx_data_valid  out  1  to uart_tx tx_data_valid
- tx_data_ready  in  1  from uart_tx tx_data_ready
- grant  out  N  one-hot current owner; 0 when idle
- busy  out  1  grant != 0
- timeout_err  out  N  sticky, set on timeout release of requester i
- err_clr  in  1  clears all timeout_err bits

Behaviour:
- Reset values: state S_IDLE; grant=0, busy=0, req_ready=0, tx_data=0, tx_data_valid=0, timeout_err=0; rr pointer=0; counters=0.
- Reset is asserted together with uart_tx. An in-flight byte is dropped and no partial handshake survives.

States:
- S_IDLE: no owner.
  - If any req_valid, pick the winner by searching upward from the rr pointer, wrapping modulo N.
  - Register grant, clear byte and timeout counters, go S_LOAD.
  - req_valid in IDLE is not an acceptance.
- S_LOAD: req_ready[g]=1, all other req_ready=0. req_ready is decoded from registers only.
  - On req_valid[g]: latch data into tx_data and last into hold_last; set tx_data_valid<=1; increment byte count; clear idle counter; go S_SEND.
  - Otherwise increment the idle counter. When it reaches TIMEOUT-1 (TIMEOUT>0): set timeout_err[g] and release.
- S_SEND: tx_data_valid=1 and tx_data is stable until tx_data_valid&&tx_data_ready.
  - On that handshake, tx_data_valid<=0 the following cycle. This is mandatory because uart_tx samples valid in its idle state.
  - Then release if hold_last, or if byte count == MAX_BURST (MAX_BURST>0). Otherwise go S_LOAD.
  - No timeout counting while in S_SEND.

Release and arbitration rules:
- Release: rr pointer <= (g+1) mod N, grant<=0, go S_IDLE.
- A requester never wins twice in a row while another is requesting.
- Latency: req_valid in IDLE at cycle 0 → grant at 1 → req_ready at 1 → tx_data_valid at 2.
- Minimum inter-byte gap inside a packet is fixed by uart_tx, roughly 10*CYCLE.
- Single requester: after release it may be regranted after one IDLE cycle. Packets are never interleaved.
- After reset, uart_tx drives tx_data_ready=0 until its first idle cycle. The arbiter simply waits in S_SEND.
- err_clr and a new timeout on the same cycle: set wins for that bit; the other bits clear.
- req_last on a byte that also hits MAX_BURST: single release, no error.
- req_valid of non-owners is ignored while granted. Non-owners' req_ready stays 0.
- Counter widths: byte counter is $clog2(MAX_BURST+1); idle counter is $clog2(TIMEOUT+1), minimum width 1.

Decomposition:
- Package uart_arb_pkg holds:
  - state enum (S_IDLE, S_LOAD, S_SEND);
  - a function for the wrapped index increment.
- Sub-module rr_pick (combinational): inputs req[N] and ptr; outputs one-hot win[N] and any. Used only in S_IDLE.
- The rest (FSM, counters, data latch) is in uart_tx_arbiter.

Test Plan:
All scenarios use a real uart_tx instance with CLK_FRE=1, BAUD_RATE=100000 (CYCLE=10), N=4, MAX_BURST=4, TIMEOUT=32.
- Single packet: req 0 sends 0x55,0xA3(last) → serial line shows the two frames LSB-first; grant=0001 throughout; release after the second handshake; busy falls.
- Contention: reqs 0,1,2 each hold a 2-byte packet valid from cycle 0 → byte order is 0,0,1,1,2,2; no interleave; rr pointer ends at 3.
- Fairness: req 1 continuously sends 1-byte packets while req 3 waits → grants alternate 1,3,1,3.
- Burst limit: req 2 sends 6 bytes with last only on the 6th → release after byte 4; if req 0 is waiting it is served next; req 2 resumes with bytes 5-6; timeout_err=0.
- Timeout: req 3 sends 1 byte (no last) then drops valid → after 32 idle cycles in S_LOAD, timeout_err[3]=1 and grant=0; err_clr pulse → timeout_err=0.
- Reset mid-frame: assert rst_n=0 during S_SEND → all outputs at reset values within the same cycle; tx_pin=1; first byte after release is transmitted cleanly.
